// File: rtl/lzs_defs_pkg.sv
// Shared LZS definitions: token types, code constants, FSM states and the
// bit-packer append payload. Used by both encode_ctl and decode_ctl.
package lzs_defs_pkg;

  localparam int unsigned ACC_W  = 20;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned CODE_W = 13;
  localparam int unsigned WID_W  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OFF_W  = 11;

  localparam logic [1:0] TOK_LIT   = 2'd0;
  localparam logic [1:0] TOK_MATCH = 2'd1;
  localparam logic [1:0] TOK_END   = 2'd2;
  localparam logic [1:0] TOK_RSVD  = 2'd3;

  localparam logic [8:0] END_CODE      = 9'b110000000;
  localparam int unsigned OFF_SHORT_LIM = 128;
  localparam logic [1:0] PFX_OFF_SHORT = 2'b11;
  localparam logic [1:0] PFX_OFF_LONG  = 2'b10;
  localparam logic [3:0] LEN_EXT_NIB   = 4'b1111;
  localparam int unsigned LEN_EXT_BASE  = 8;
  localparam int unsigned LEN_EXT_STEP  = 15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TOK  = 3'd1,
    S_LEN  = 3'd2,
    S_EXT  = 3'd3,
    S_PAD  = 3'd4,
    S_END  = 3'd5
  } state_e;

  // Right-aligned code and its bit width, appended MSB-first.
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [WID_W-1:0]  width;
  } code_t;

  // Length prefix for a length already capped to 2..8 (8 means ">= 8").
  function automatic code_t len_prefix(input logic [3:0] len_cap);
    code_t c;
    c.code  = '0;
    c.width = 4'd4;
    case (len_cap)
      4'd2:    begin c.code = CODE_W'(2'b00); c.width = 4'd2; end
      4'd3:    begin c.code = CODE_W'(2'b01); c.width = 4'd2; end
      4'd4:    begin c.code = CODE_W'(2'b10); c.width = 4'd2; end
      4'd5:    c.code = CODE_W'(4'b1100);
      4'd6:    c.code = CODE_W'(4'b1101);
      4'd7:    c.code = CODE_W'(4'b1110);
      default: c.code = CODE_W'(LEN_EXT_NIB);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lzs_bitpack.sv
// MSB-first bit accumulator: appends variable-width codes below the pending
// bits and drains the top byte whenever at least 8 bits are held.
module lzs_bitpack
  import lzs_defs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  code_t             code_i,
  input  logic              out_ready_i,
  output logic [BYTE_W-1:0] out_data_o,
  output logic              out_valid_o,
  output logic [CNT_W-1:0]  bitcnt_o
);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] mask;
  logic [CNT_W-1:0]  sh;
  logic              drain;

  assign out_valid_o = (cnt_q >= CNT_W'(BYTE_W));
  assign out_data_o  = acc_q[ACC_W-1 -: BYTE_W];
  assign bitcnt_o    = cnt_q;
  assign drain       = out_valid_o && out_ready_i;

  // Callers only push while fewer than 8 bits are held, so push and drain
  // are mutually exclusive and the shift amount never goes negative.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    mask  = CODE_W'((14'd1 << code_i.width) - 14'd1);
    sh    = CNT_W'(ACC_W) - cnt_q - CNT_W'(code_i.width);
    if (drain) begin
      acc_d = acc_q << BYTE_W;
      cnt_d = cnt_q - CNT_W'(BYTE_W);
    end else if (push_i) begin
      acc_d = acc_q | (ACC_W'(code_i.code & mask) << sh);
      cnt_d = cnt_q + CNT_W'(code_i.width);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/encode_ctl.sv
// LZS encoder back end: turns literal/match/end tokens into the LZS bit
// stream and hands it to lzs_bitpack for byte packing.
module encode_ctl
  import lzs_defs_pkg::*;
#(
  parameter int unsigned LEN_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_encode,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic [1:0]        tok_type,
  input  logic [7:0]        tok_lit,
  input  logic [OFF_W-1:0]  tok_off,
  input  logic [LEN_W-1:0]  tok_len,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              all_end
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] bitcnt;
  logic             room;
  logic             tok_take;
  logic             rem_ge_step;
  logic [3:0]       len_cap;
  logic             push;
  code_t            code;

  assign room        = (bitcnt < CNT_W'(BYTE_W));
  assign tok_take    = (state_q == S_TOK) && tok_valid && room && (tok_type != TOK_RSVD);
  assign rem_ge_step = (rem_q >= LEN_W'(LEN_EXT_STEP));
  assign len_cap     = (len_q >= LEN_W'(LEN_EXT_BASE)) ? 4'd8 : {1'b0, len_q[2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (ce_encode) state_d = S_TOK;
      S_TOK: begin
        if (tok_take && tok_type == TOK_MATCH) state_d = S_LEN;
        if (tok_take && tok_type == TOK_END)   state_d = S_PAD;
      end
      S_LEN:  if (room) state_d = (len_cap == 4'd8) ? S_EXT : S_TOK;
      S_EXT:  if (room && !rem_ge_step) state_d = S_TOK;
      S_PAD:  if (bitcnt == '0) state_d = S_END;
      S_END:  state_d = S_END;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tok_ready  = 1'b0;
    all_end    = 1'b0;
    push       = 1'b0;
    code.code  = '0;
    code.width = '0;
    case (state_q)
      S_TOK: begin
        tok_ready = tok_take;
        push      = tok_take;
        case (tok_type)
          TOK_LIT: begin
            code.code  = CODE_W'({1'b0, tok_lit});
            code.width = 4'd9;
          end
          TOK_MATCH: begin
            if (tok_off < OFF_W'(OFF_SHORT_LIM)) begin
              code.code  = CODE_W'({PFX_OFF_SHORT, tok_off[6:0]});
              code.width = 4'd9;
            end else begin
              code.code  = CODE_W'({PFX_OFF_LONG, tok_off});
              code.width = 4'd13;
            end
          end
          default: begin
            code.code  = CODE_W'(END_CODE);
            code.width = 4'd9;
          end
        endcase
      end
      S_LEN: begin
        push = room;
        code = len_prefix(len_cap);
      end
      S_EXT: begin
        push       = room;
        code.code  = CODE_W'(rem_ge_step ? LEN_EXT_NIB : rem_q[3:0]);
        code.width = 4'd4;
      end
      S_PAD: begin
        // Zero-fill up to the next byte boundary.
        push       = room && (bitcnt != '0);
        code.width = 4'(CNT_W'(BYTE_W) - bitcnt);
      end
      S_END: all_end = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    len_d = len_q;
    rem_d = rem_q;
    if (tok_take && tok_type == TOK_MATCH) len_d = tok_len;
    if (state_q == S_LEN && room)          rem_d = len_q - LEN_W'(LEN_EXT_BASE);
    if (state_q == S_EXT && room && rem_ge_step) rem_d = rem_q - LEN_W'(LEN_EXT_STEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= '0;
      rem_q <= '0;
    end else begin
      len_q <= len_d;
      rem_q <= rem_d;
    end
  end

  lzs_bitpack u_bitpack (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .code_i      (code),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .bitcnt_o    (bitcnt)
  );

endmodule

// File: tb/tb_encode_ctl.sv
// Directed bench for encode_ctl: hand-computed byte streams plus a bit-level
// reference encoder for the longer literal and mixed-token runs.
module tb_encode_ctl;
  import lzs_defs_pkg::*;

  localparam int unsigned LEN_W = 12;

  logic             clk;
  logic             rst;
  logic             ce_encode;
  logic             tok_valid;
  logic             tok_ready;
  logic [1:0]       tok_type;
  logic [7:0]       tok_lit;
  logic [10:0]      tok_off;
  logic [LEN_W-1:0] tok_len;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             all_end;

  int total = 0;
  int bad   = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  bit         exp_bits[$];

  encode_ctl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce_encode (ce_encode),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_type  (tok_type),
    .tok_lit   (tok_lit),
    .tok_off   (tok_off),
    .tok_len   (tok_len),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .all_end   (all_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs only change just after posedge, so a negedge sample sees the
  // handshake that the next posedge will complete.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back(out_data);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    ce_encode = 1'b0;
    tok_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    got.delete();
    exp_q.delete();
    exp_bits.delete();
    ce_encode = 1'b1;
    tick();
  endtask

  task automatic send(input logic [1:0] t, input logic [7:0] lit, input int off, input int len);
    bit ok;
    ok = 1'b0;
    chk("tok_legal", 32'((t == TOK_RSVD) || (t == TOK_MATCH && (off == 0 || len < 2))), 0);
    tok_valid = 1'b1;
    tok_type  = t;
    tok_lit   = lit;
    tok_off   = 11'(off);
    tok_len   = LEN_W'(len);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tok_ready) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    tok_valid = 1'b0;
    chk("tok_accept", 32'(ok), 1);
  endtask

  task automatic wait_end();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (all_end) break;
    end
    chk("all_end", 32'(all_end), 1);
    tick();
  endtask

  task automatic check_stream(input string tag);
    chk($sformatf("%s_nbytes", tag), 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i),
          (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(exp_q[i]));
  endtask

  task automatic add_bits(input int v, input int w);
    for (int i = w - 1; i >= 0; i--) exp_bits.push_back(v[i]);
  endtask

  task automatic model_lit(input int b);
    add_bits(0, 1);
    add_bits(b, 8);
  endtask

  task automatic model_match(input int off, input int len);
    int r;
    if (off < 128) begin
      add_bits(3, 2);
      add_bits(off, 7);
    end else begin
      add_bits(2, 2);
      add_bits(off, 11);
    end
    if (len <= 4) add_bits(len - 2, 2);
    else if (len <= 7) add_bits(len + 7, 4);
    else begin
      add_bits(15, 4);
      r = len - 8;
      while (r >= 15) begin
        add_bits(15, 4);
        r -= 15;
      end
      add_bits(r, 4);
    end
  endtask

  task automatic model_end();
    logic [7:0] b;
    add_bits(9'b110000000, 9);
    while (exp_bits.size() % 8 != 0) exp_bits.push_back(1'b0);
    for (int i = 0; i < exp_bits.size(); i += 8) begin
      for (int j = 0; j < 8; j++) b[7-j] = exp_bits[i+j];
      exp_q.push_back(b);
    end
  endtask

  initial begin
    int  k;
    bit  seen;
    int  lit;
    int  off;
    int  len;

    rst       = 1'b1;
    ce_encode = 1'b1;
    tok_valid = 1'b1;
    tok_type  = TOK_LIT;
    tok_lit   = 8'h55;
    tok_off   = 11'd1;
    tok_len   = LEN_W'(2);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tok_ready", 32'(tok_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_all_end",   32'(all_end),   0);
    tok_valid = 1'b0;
    rst       = 1'b0;
    tick();

    // LIT 0x41, END
    send(TOK_LIT, 8'h41, 1, 2);
    send(TOK_END, 8'h00, 1, 2);
    wait_end();
    exp_q = '{8'h20, 8'hE0, 8'h00};
    check_stream("lit41");

    // MATCH off=5 len=3, END
    do_reset();
    send(TOK_MATCH, 8'h00, 5, 3);
    send(TOK_END, 8'h00, 1, 2);
    wait_end();
    exp_q = '{8'hC2, 8'hB8, 8'h00};
    check_stream("m5_3");

    // MATCH off=300 len=8: 10 00100101100 1111 0000, END
    do_reset();
    send(TOK_MATCH, 8'h00, 300, 8);
    send(TOK_END, 8'h00, 1, 2);
    wait_end();
    exp_q = '{8'h89, 8'h67, 8'h86, 8'h00};
    check_stream("m300_8");

    // len=22: suffix 1111 1110
    do_reset();
    send(TOK_MATCH, 8'h00, 5, 22);
    send(TOK_END, 8'h00, 1, 2);
    wait_end();
    exp_q = '{8'hC2, 8'hFF, 8'h60, 8'h00};
    check_stream("m5_22");

    // len=23: suffix 1111 1111 0000
    do_reset();
    send(TOK_MATCH, 8'h00, 5, 23);
    send(TOK_END, 8'h00, 1, 2);
    wait_end();
    exp_q = '{8'hC2, 8'hFF, 8'h86, 8'h00};
    check_stream("m5_23");

    // 64 literals with a 20-cycle sink stall mid-stream
    do_reset();
    for (int i = 0; i < 64; i++) begin
      lit = int'($urandom_range(0, 255));
      if (i == 32) begin
        k = 0;
        while (out_valid && k < 50) begin
          tick();
          k++;
        end
        out_ready = 1'b0;
      end
      if (i == 33) begin
        tok_valid = 1'b1;
        tok_type  = TOK_LIT;
        tok_lit   = 8'(lit);
        seen      = 1'b0;
        repeat (20) begin
          @(negedge clk);
          if (tok_ready) seen = 1'b1;
        end
        chk("bp_tok_ready", 32'(seen), 0);
        chk("bp_out_valid", 32'(out_valid), 1);
        tick();
        out_ready = 1'b1;
      end
      model_lit(lit);
      send(TOK_LIT, 8'(lit), 1, 2);
    end
    send(TOK_END, 8'h00, 1, 2);
    model_end();
    wait_end();
    check_stream("lit64");

    // Mixed random tokens against the reference encoder
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        lit = int'($urandom_range(0, 255));
        model_lit(lit);
        send(TOK_LIT, 8'(lit), 1, 2);
      end else begin
        off = int'($urandom_range(1, 2047));
        len = int'($urandom_range(2, 600));
        model_match(off, len);
        send(TOK_MATCH, 8'h00, off, len);
      end
    end
    send(TOK_END, 8'h00, 1, 2);
    model_end();
    wait_end();
    check_stream("rand");

    // Reset while emitting length-extension nibbles
    do_reset();
    send(TOK_MATCH, 8'h00, 5, 600);
    repeat (6) tick();
    rst = 1'b1;
    #1;
    chk("midrst_tok_ready", 32'(tok_ready), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_data",  32'(out_data),  0);
    chk("midrst_all_end",   32'(all_end),   0);
    repeat (2) tick();
    rst = 1'b0;
    got.delete();
    tick();
    send(TOK_LIT, 8'hFF, 1, 2);
    send(TOK_END, 8'h00, 1, 2);
    wait_end();
    exp_q = '{8'h7F, 8'hE0, 8'h00};
    check_stream("litFF");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
